// File: rtl/div_unit_pkg.sv
// Shared widths, RV32M divide op encodings and result constants for div_unit.
package div_unit_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;

    // funct3 encodings; bit 2 set marks a divide op, bit 1 selects remainder, bit 0 unsigned
    localparam logic [2:0] INST_DIV  = 3'b100;
    localparam logic [2:0] INST_DIVU = 3'b101;
    localparam logic [2:0] INST_REM  = 3'b110;
    localparam logic [2:0] INST_REMU = 3'b111;

    localparam logic [RegBus-1:0] DivResultZero    = 32'h0000_0000;
    localparam logic [RegBus-1:0] DivResultAllOnes = 32'hFFFF_FFFF;
    localparam logic [RegBus-1:0] DivIntMin        = 32'h8000_0000;

    function automatic logic [RegBus-1:0] abs32(input logic [RegBus-1:0] v);
        return v[RegBus-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring RV32M divider: 34-cycle result (2 for div-by-zero/overflow) as a one-cycle
// register-file write; busy_o stalls EX, start_i ignored while busy, flush_i aborts with no write.
module div_unit
    import div_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            op_i,
    input  logic [RegBus-1:0]     dividend_i,
    input  logic [RegBus-1:0]     divisor_i,
    input  logic [RegAddrBus-1:0] waddr_i,
    output logic                  busy_o,
    output logic                  ready_o,
    output logic                  we_o,
    output logic [RegAddrBus-1:0] waddr_o,
    output logic [RegBus-1:0]     wdata_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_CALC  = 2'd2,
        S_END   = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic              op_rem;
    logic              op_uns;
    logic [RegBus-1:0] qr;
    logic [RegBus-1:0] dvs;
    logic [RegBus-1:0] rem;
    logic [4:0]        cnt;
    logic              neg_quot;
    logic              neg_rem;

    logic              accept;
    logic              div_zero;
    logic              overflow;
    logic              special;
    logic [RegBus-1:0] special_res;
    logic [RegBus:0]   trial;
    logic [RegBus:0]   diff;
    logic              qbit;
    logic [RegBus-1:0] rem_nxt;
    logic [RegBus-1:0] qr_nxt;
    logic [RegBus-1:0] quot_fin;
    logic [RegBus-1:0] rem_fin;
    logic              last_iter;

    assign accept    = start_i && op_i[2] && !flush_i;
    assign last_iter = (cnt == 5'd31);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        ready_o   = 1'b0;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_START;
            S_START: state_nxt = special ? S_END : S_CALC;
            S_CALC:  if (last_iter) state_nxt = S_END;
            S_END:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) begin
            state_nxt = S_IDLE;
        end
        busy_o  = (state != S_IDLE);
        ready_o = (state == S_END) && !flush_i;
    end

    assign we_o = ready_o;

    // Special cases are decided on the raw latched operands, before the absolute-value step.
    always_comb begin
        div_zero    = (dvs == DivResultZero);
        overflow    = !op_uns && (qr == DivIntMin) && (dvs == DivResultAllOnes);
        special     = div_zero || overflow;
        special_res = DivResultZero;
        if (div_zero) begin
            special_res = op_rem ? qr : DivResultAllOnes;
        end else if (overflow) begin
            special_res = op_rem ? DivResultZero : DivIntMin;
        end
    end

    // One restoring step: qr shifts the dividend out of its MSB while quotient bits enter its LSB.
    always_comb begin
        trial    = {rem, qr[RegBus-1]};
        diff     = trial - {1'b0, dvs};
        qbit     = !diff[RegBus];
        rem_nxt  = qbit ? diff[RegBus-1:0] : trial[RegBus-1:0];
        qr_nxt   = {qr[RegBus-2:0], qbit};
        quot_fin = neg_quot ? (~qr_nxt + 32'd1) : qr_nxt;
        rem_fin  = neg_rem ? (~rem_nxt + 32'd1) : rem_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_rem   <= 1'b0;
            op_uns   <= 1'b0;
            qr       <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            waddr_o  <= '0;
            wdata_o  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_rem  <= op_i[1];
                        op_uns  <= op_i[0];
                        qr      <= dividend_i;
                        dvs     <= divisor_i;
                        waddr_o <= waddr_i;
                    end
                end
                S_START: begin
                    neg_quot <= !op_uns && (qr[RegBus-1] ^ dvs[RegBus-1]);
                    neg_rem  <= !op_uns && qr[RegBus-1];
                    rem      <= '0;
                    cnt      <= '0;
                    if (!op_uns) begin
                        qr  <= abs32(qr);
                        dvs <= abs32(dvs);
                    end
                    if (special) begin
                        wdata_o <= special_res;
                    end
                end
                S_CALC: begin
                    qr  <= qr_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + 5'd1;
                    if (last_iter) begin
                        wdata_o <= op_rem ? rem_fin : quot_fin;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: a cycle-level model of the expected write stream checked every cycle,
// plus hand-computed result/latency literals for each directed operation.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  op_i;
    logic [31:0] dividend_i;
    logic [31:0] divisor_i;
    logic [4:0]  waddr_i;
    logic        busy_o;
    logic        ready_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    div_unit dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .flush_i    (flush_i),
        .op_i       (op_i),
        .dividend_i (dividend_i),
        .divisor_i  (divisor_i),
        .waddr_i    (waddr_i),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .we_o       (we_o),
        .waddr_o    (waddr_o),
        .wdata_o    (wdata_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit          m_act    = 1'b0;
    int          m_start  = 0;
    int          m_end    = 0;
    bit          m_cancel = 1'b0;
    logic [31:0] m_data   = '0;
    logic [4:0]  m_addr   = '0;

    function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa;
        int sb;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            sa = a;
            sb = b;
            return op[1] ? (sa % sb) : (sa / sb);
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    function automatic bit ref_special(input logic [2:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic bit m_busy(input int c);
        return m_act && (c > m_start) && (c <= m_end);
    endfunction

    task automatic model_accept();
        if (start_i && !m_busy(cyc) && op_i[2] && !flush_i) begin
            m_act    = 1'b1;
            m_start  = cyc;
            m_end    = cyc + (ref_special(op_i, dividend_i, divisor_i) ? 2 : 34);
            m_cancel = 1'b0;
            m_data   = ref_res(op_i, dividend_i, divisor_i);
            m_addr   = waddr_i;
        end
    endtask

    task automatic model_abort();
        if (m_busy(cyc)) begin
            m_end    = cyc;
            m_cancel = 1'b1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    bit          chk_en  = 1'b0;
    int          wr_cnt  = 0;
    int          wr_cyc  = 0;
    logic [31:0] wr_dat  = '0;
    logic [4:0]  wr_addr = '0;
    logic        e_busy;
    logic        e_we;

    always @(negedge clk) begin
        if (chk_en) begin
            e_busy = m_busy(cyc);
            e_we   = m_act && (cyc == m_end) && !m_cancel;
            chk("busy_o", {31'd0, busy_o}, {31'd0, e_busy});
            chk("ready_o", {31'd0, ready_o}, {31'd0, e_we});
            chk("we_o", {31'd0, we_o}, {31'd0, e_we});
            if (e_we) begin
                chk("wdata_o", wdata_o, m_data);
                chk("waddr_o", {27'd0, waddr_o}, {27'd0, m_addr});
            end
            if (we_o) begin
                wr_cnt++;
                wr_cyc  = cyc;
                wr_dat  = wdata_o;
                wr_addr = waddr_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        start_i    = 1'b1;
        op_i       = op;
        dividend_i = a;
        divisor_i  = b;
        waddr_i    = rd;
        model_accept();
        step();
        start_i = 1'b0;
    endtask

    task automatic wait_write(input int n0);
        int k;
        k = 0;
        while (wr_cnt == n0 && k < 40) begin
            step();
            k++;
        end
        chk("write_seen", wr_cnt - n0, 32'd1);
    endtask

    task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic [31:0] exp_val, input int exp_lat);
        int c0;
        int n0;
        c0 = cyc;
        n0 = wr_cnt;
        issue(op, a, b, rd);
        wait_write(n0);
        chk({name, "_val"}, wr_dat, exp_val);
        chk({name, "_lat"}, wr_cyc - c0, exp_lat);
        chk({name, "_rd"}, {27'd0, wr_addr}, {27'd0, rd});
    endtask

    task automatic flush_test(input string name, input int at);
        int c0;
        int n0;
        c0 = cyc;
        n0 = wr_cnt;
        issue(3'b101, 32'd1000, 32'd3, 5'd9);
        while (cyc < c0 + at) step();
        flush_i = 1'b1;
        model_abort();
        step();
        flush_i = 1'b0;
        repeat (30) step();
        chk(name, wr_cnt - n0, 32'd0);
    endtask

    initial begin
        int c0;
        int n0;
        rst        = 1'b1;
        start_i    = 1'b0;
        flush_i    = 1'b0;
        op_i       = 3'b000;
        dividend_i = '0;
        divisor_i  = '0;
        waddr_i    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_ready", {31'd0, ready_o}, 32'd0);
        chk("rst_we", {31'd0, we_o}, 32'd0);
        chk("rst_waddr", {27'd0, waddr_o}, 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        step();
        rst    = 1'b0;
        chk_en = 1'b1;
        step();

        run_check("divu_100_7", 3'b101, 32'd100, 32'd7, 5'd3, 32'd14, 34);
        run_check("remu_100_7", 3'b111, 32'd100, 32'd7, 5'd3, 32'd2, 34);
        run_check("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd10, 32'hFFFF_FFFD, 34);
        run_check("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd11, 32'hFFFF_FFFF, 34);
        run_check("rem_7_m2", 3'b110, 32'd7, 32'hFFFF_FFFE, 5'd12, 32'd1, 34);
        run_check("div_100_m7", 3'b100, 32'd100, 32'hFFFF_FFF9, 5'd13, 32'hFFFF_FFF2, 34);
        run_check("rem_m100_7", 3'b110, 32'hFFFF_FF9C, 32'd7, 5'd14, 32'hFFFF_FFFE, 34);
        run_check("divu_max_1", 3'b101, 32'hFFFF_FFFF, 32'd1, 5'd15, 32'hFFFF_FFFF, 34);
        run_check("remu_max_10", 3'b111, 32'hFFFF_FFFF, 32'd10, 5'd16, 32'd5, 34);
        run_check("divu_7_100_x0", 3'b101, 32'd7, 32'd100, 5'd0, 32'd0, 34);
        run_check("div_5_0", 3'b100, 32'd5, 32'd0, 5'd17, 32'hFFFF_FFFF, 2);
        run_check("remu_5_0", 3'b111, 32'd5, 32'd0, 5'd18, 32'd5, 2);
        run_check("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h8000_0000, 2);
        run_check("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0, 2);

        // illegal op and start-with-flush in IDLE: neither may launch an operation
        n0 = wr_cnt;
        issue(3'b011, 32'd50, 32'd5, 5'd1);
        repeat (4) step();
        flush_i = 1'b1;
        issue(3'b101, 32'd50, 32'd5, 5'd1);
        flush_i = 1'b0;
        repeat (40) step();
        chk("ignored_starts", wr_cnt - n0, 32'd0);

        flush_test("flush_c12_nowrite", 12);
        flush_test("flush_c34_nowrite", 34);

        // start pulses while busy are ignored, then a back-to-back op in the first idle cycle
        c0 = cyc;
        n0 = wr_cnt;
        issue(3'b101, 32'd100, 32'd7, 5'd21);
        while (cyc < c0 + 5) step();
        while (cyc <= c0 + 20) begin
            start_i    = cyc[0];
            op_i       = 3'b100;
            dividend_i = 32'd999;
            divisor_i  = 32'd0;
            waddr_i    = 5'd30;
            model_accept();
            step();
        end
        start_i = 1'b0;
        wait_write(n0);
        chk("busy_start_val", wr_dat, 32'd14);
        chk("busy_start_lat", wr_cyc - c0, 32'd34);
        n0 = wr_cnt;
        chk("b2b_issue_cycle", cyc - c0, 32'd35);
        issue(3'b111, 32'd100, 32'd7, 5'd22);
        wait_write(n0);
        chk("b2b_val", wr_dat, 32'd2);
        chk("b2b_end_cycle", wr_cyc - c0, 32'd69);

        // synchronous reset mid-operation
        c0 = cyc;
        n0 = wr_cnt;
        issue(3'b100, 32'hFFFF_FF9C, 32'd7, 5'd6);
        while (cyc < c0 + 20) step();
        rst = 1'b1;
        model_abort();
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_waddr", {27'd0, waddr_o}, 32'd0);
        chk("midrst_wdata", wdata_o, 32'd0);
        step();
        repeat (20) step();
        chk("midrst_nowrite", wr_cnt - n0, 32'd0);
        run_check("post_rst_div", 3'b100, 32'hFFFF_FF9C, 32'd7, 5'd6, 32'hFFFF_FFF2, 34);

        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV32M divider that sits beside the EX stage and writes its result straight into the register file write port. Accepts one DIV/DIVU/REM/REMU operation from EX. Runs a 32-iteration restoring division, one quotient bit per cycle. Presents a single-cycle write (data, address, enable) aligned with the register file's `we`/`waddr`/`wdata` inputs. EX stalls on `busy_o`; the pipeline controller cancels with `flush_i`.

## Interface
Parameters:
- none; widths come from `defines.v`: `RegBus` is 32 bits, `RegAddrBus` is 5 bits.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start_i` in 1: request; sampled only in IDLE.
- `flush_i` in 1: synchronous abort of any operation in flight.
- `op_i` in 3: funct3; 100 DIV, 101 DIVU, 110 REM, 111 REMU; 0xx is illegal and ignored.
- `dividend_i` in 32: rs1 value, sampled with `start_i`.
- `divisor_i` in 32: rs2 value, sampled with `start_i`.
- `waddr_i` in 5: rd, sampled with `start_i`.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `ready_o` out 1: one-cycle completion pulse.
- `we_o` out 1: register write enable; equals `ready_o`.
- `waddr_o` out 5: latched rd.
- `wdata_o` out 32: result; valid only while `ready_o`=1.

## Operation
- **States:** IDLE, START, CALC, END.
- **IDLE:**
  - If `start_i` & legal op & !`flush_i`: latch operands, op and rd; go to START.
  - Otherwise stay in IDLE.
- **START:**
  - Divisor = 0: result is 0xFFFFFFFF for DIV/DIVU; result is the dividend for REM/REMU. Go to END.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): DIV gives 0x80000000, REM gives 0. Go to END.
  - Otherwise: take absolute values (signed ops only), clear the 33-bit partial remainder and the 5-bit counter, go to CALC.
- **CALC:** each cycle:
  - Shift the partial remainder left, bringing in the dividend MSB.
  - Trial-subtract the divisor. If the result is non-negative, keep it and shift in quotient bit 1; else shift in 0.
  - Counter increments. After the 32nd iteration (counter wrap 31→0), go to END.
- **END:**
  - Sign-correct the result: quotient is negated if the operand signs differ; remainder takes the dividend's sign.
  - Drive the result on `wdata_o` and assert `ready_o`/`we_o` for exactly one cycle, then return to IDLE.
- **`flush_i`:** in any state, the next state is IDLE. No write is issued, including when `flush_i` arrives in END (`we_o` is forced low that cycle).
- **`start_i` while busy:** ignored. EX must hold the instruction until it sees `busy_o` low.
- **rd = x0:** `we_o` is still pulsed; the register file drops writes to x0.
- **Reset values:**
  - `busy_o`, `ready_o`, `we_o` = 0.
  - `waddr_o` = 0, `wdata_o` = 0.
  - State = IDLE, counter = 0.
  - Reset in mid-operation takes effect at the next edge and produces no write.

## Timing
- Cycle 0 is the cycle in which `start_i` is high in IDLE.
- `busy_o` is high from cycle 1 until END is left.
- Normal path: START is cycle 1, CALC is cycles 2–33, END is cycle 34. `ready_o`/`we_o` are high in cycle 34 only; `busy_o` is low in cycle 35.
- Special-case path: END is cycle 2.
- A new `start_i` may be accepted in the first cycle with `busy_o`=0.
- `wdata_o`/`waddr_o` are registered. `ready_o` and `we_o` are decoded from state & !`flush_i`.
- The register file forwards `wdata` when `we` and `waddr` match a read, so a dependent read in cycle 34 sees the new value.

## Structure
- Add to `defines.v`:
  - Op encodings `INST_DIV`, `INST_DIVU`, `INST_REM`, `INST_REMU`.
  - `DivResultZero`, `DivResultAllOnes`.
- State encoding is a local parameter inside the module.
- Single module, no sub-modules. Datapath is one 33-bit subtractor plus the quotient and remainder shift registers.

## Test plan
- **DIVU:** 100 / 7 → `we_o`=1, `wdata_o`=14, `waddr_o`=rd, in cycle 34 only; REMU on the same operands gives 2.
- **Signed:** DIV −7 / 2 → 0xFFFFFFFD. REM −7 / 2 → 0xFFFFFFFF. REM 7 / −2 → 1.
- **Divide by zero and overflow:**
  - DIV 5 / 0 → 0xFFFFFFFF in cycle 2; REMU 5 / 0 → 5.
  - DIV 0x80000000 / −1 → 0x80000000; REM → 0.
- **Flush:** `flush_i` in cycle 12 → no `we_o` pulse at any point; `busy_o` low in cycle 13. Repeat with `flush_i` in cycle 34 → no write.
- **Start while busy:** `start_i` pulses during cycles 5–20 are ignored. A back-to-back `start_i` in cycle 35 completes in cycle 69.
- **Reset:** `rst` in cycle 20 → all outputs 0 from the next edge, no write, IDLE; the following op produces a correct result.
